branch_redirect_ctrl: RTL and testbench

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

---
 rtl/branch_redirect_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Arbitrates branch redirects from two execution lanes (A and B) onto a single
// shared PC redirect port. It also sequences lane flushes and unified/split
// mode changes.
//
// In unified mode, lane B never redirects, and a lane A redirect flushes both
// lanes. In split mode, each lane redirects and flushes on its own. When both
// lanes take a branch in the same cycle, lane A wins and lane B's redirect is
// replayed one cycle later.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   brA_valid/taken/target    lane A branch resolution
//   brB_valid/taken/target    lane B branch resolution
//   mode_req_valid, mode_req  mode change request (held until mode_req_ready)
//   mode_req_ready            one-cycle acknowledge of the mode request
//   mode                      current mode (1 unified, 0 split)
//   pc_redirect_valid/lane/target  one-cycle redirect strobe, owner, address
//   flushA, flushB            kill in-flight instructions of lane A / B
//   issue_stall               block issue on both lanes
//
// All outputs are registered. Redirect lane/target hold their last value
// while pc_redirect_valid is low.
// ---------------------------------------------------------------------------
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,    // legal range 1..15
    parameter bit RESET_MODE   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            brA_valid,
    input  logic            brA_taken,
    input  logic [XLEN-1:0] brA_target,
    input  logic            brB_valid,
    input  logic            brB_taken,
    input  logic [XLEN-1:0] brB_target,
    input  logic            mode_req_valid,
    input  logic            mode_req,
    output logic            mode_req_ready,
    output logic            mode,
    output logic            pc_redirect_valid,
    output logic            pc_redirect_lane,
    output logic [XLEN-1:0] pc_redirect_target,
    output logic            flushA,
    output logic            flushB,
    output logic            issue_stall
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    typedef enum logic [1:0] {IDLE, FLUSH, PEND_B, MODE_SW} state_t;

    state_t          stateReg;
    logic [3:0]      cntAReg, cntBReg;
    logic [3:0]      cntANext, cntBNext;
    logic [XLEN-1:0] pendTargetReg;
    logic            pendModeReg;

    logic takeA, takeB;
    logic acceptA, acceptB;
    logic modeAck, modeStart;
    logic countersDone;

    // Work out which requests are accepted this cycle and what the flush
    // counters become. A flush output is high exactly while its counter is
    // nonzero. The counter is loaded at the accepting edge, so the flush covers
    // FLUSH_CYCLES cycles starting with the redirect cycle.
    always_comb begin
        takeA     = brA_valid & brA_taken & ~flushA;
        takeB     = brB_valid & brB_taken & ~flushB & ~mode;
        acceptA   = 1'b0;
        acceptB   = 1'b0;
        modeAck   = 1'b0;
        modeStart = 1'b0;
        cntANext  = (cntAReg != 4'd0) ? cntAReg - 4'd1 : 4'd0;
        cntBNext  = (cntBReg != 4'd0) ? cntBReg - 4'd1 : 4'd0;

        case (stateReg)
            IDLE, FLUSH: begin
                acceptA = takeA;
                acceptB = takeB;
                if (acceptA) begin
                    cntANext = FLUSH_LOAD;
                    // Unified mode: a lane A redirect kills both lanes.
                    if (mode) begin
                        cntBNext = FLUSH_LOAD;
                    end
                end else if (acceptB) begin
                    // On a dual take, B's flush starts with its delayed redirect instead.
                    cntBNext = FLUSH_LOAD;
                end
                // Mode requests are serviced only when the pipe is quiet. The
                // ready guard stops the cycle that completes a handshake from
                // being taken as a fresh request.
                if (stateReg == IDLE && !takeA && !takeB &&
                    mode_req_valid && !mode_req_ready) begin
                    if (mode_req == mode) begin
                        modeAck = 1'b1;
                    end else begin
                        modeStart = 1'b1;
                        cntANext  = FLUSH_LOAD;
                        cntBNext  = FLUSH_LOAD;
                    end
                end
            end
            PEND_B: begin
                cntBNext = FLUSH_LOAD;
            end
            default: begin
            end
        endcase

        countersDone = (cntANext == 4'd0) && (cntBNext == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg           <= IDLE;
            cntAReg            <= 4'd0;
            cntBReg            <= 4'd0;
            pendTargetReg      <= '0;
            pendModeReg        <= RESET_MODE;
            mode               <= RESET_MODE;
            mode_req_ready     <= 1'b0;
            pc_redirect_valid  <= 1'b0;
            pc_redirect_lane   <= 1'b0;
            pc_redirect_target <= '0;
            flushA             <= 1'b0;
            flushB             <= 1'b0;
            issue_stall        <= 1'b0;
        end else begin
            cntAReg           <= cntANext;
            cntBReg           <= cntBNext;
            flushA            <= (cntANext != 4'd0);
            flushB            <= (cntBNext != 4'd0);
            pc_redirect_valid <= 1'b0;
            mode_req_ready    <= 1'b0;

            case (stateReg)
                IDLE, FLUSH: begin
                    if (acceptA) begin
                        pc_redirect_valid  <= 1'b1;
                        pc_redirect_lane   <= 1'b0;
                        pc_redirect_target <= brA_target;
                        if (acceptB) begin
                            // Lane B loses arbitration; replay its redirect next cycle.
                            pendTargetReg <= brB_target;
                            issue_stall   <= 1'b1;
                            stateReg      <= PEND_B;
                        end else begin
                            stateReg <= FLUSH;
                        end
                    end else if (acceptB) begin
                        pc_redirect_valid  <= 1'b1;
                        pc_redirect_lane   <= 1'b1;
                        pc_redirect_target <= brB_target;
                        stateReg           <= FLUSH;
                    end else if (modeAck) begin
                        mode_req_ready <= 1'b1;
                    end else if (modeStart) begin
                        pendModeReg <= mode_req;
                        issue_stall <= 1'b1;
                        stateReg    <= MODE_SW;
                    end else if (countersDone) begin
                        stateReg <= IDLE;
                    end
                end
                PEND_B: begin
                    pc_redirect_valid  <= 1'b1;
                    pc_redirect_lane   <= 1'b1;
                    pc_redirect_target <= pendTargetReg;
                    issue_stall        <= 1'b0;
                    stateReg           <= FLUSH;
                end
                MODE_SW: begin
                    // Switch modes in the first cycle with both lanes drained.
                    if (countersDone) begin
                        mode           <= pendModeReg;
                        mode_req_ready <= 1'b1;
                        issue_stall    <= 1'b0;
                        stateReg       <= IDLE;
                    end
                end
                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl
//
// Each step drives one cycle of inputs on the falling edge. It pushes the
// outputs expected after the following rising edge onto a scoreboard queue.
// On the next falling edge, that entry is popped and compared against the DUT.
// ---------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            brA_valid, brA_taken;
    logic [XLEN-1:0] brA_target;
    logic            brB_valid, brB_taken;
    logic [XLEN-1:0] brB_target;
    logic            mode_req_valid, mode_req;
    logic            mode_req_ready, mode;
    logic            pc_redirect_valid, pc_redirect_lane;
    logic [XLEN-1:0] pc_redirect_target;
    logic            flushA, flushB, issue_stall;

    branch_redirect_ctrl #(
        .XLEN         (XLEN),
        .FLUSH_CYCLES (2),
        .RESET_MODE   (1'b1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .brA_valid          (brA_valid),
        .brA_taken          (brA_taken),
        .brA_target         (brA_target),
        .brB_valid          (brB_valid),
        .brB_taken          (brB_taken),
        .brB_target         (brB_target),
        .mode_req_valid     (mode_req_valid),
        .mode_req           (mode_req),
        .mode_req_ready     (mode_req_ready),
        .mode               (mode),
        .pc_redirect_valid  (pc_redirect_valid),
        .pc_redirect_lane   (pc_redirect_lane),
        .pc_redirect_target (pc_redirect_target),
        .flushA             (flushA),
        .flushB             (flushB),
        .issue_stall        (issue_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            rst;
        logic            aV;
        logic            aT;
        logic [XLEN-1:0] aTgt;
        logic            bV;
        logic            bT;
        logic [XLEN-1:0] bTgt;
        logic            mV;
        logic            mR;
    } in_t;

    typedef struct packed {
        logic            rv;
        logic            lane;
        logic [XLEN-1:0] tgt;
        logic            fA;
        logic            fB;
        logic            st;
        logic            md;
        logic            rdy;
    } out_t;

    typedef struct {
        in_t  stim;
        out_t exp;
    } vec_t;

    vec_t tbl[$];
    out_t expQ[$];
    int   tagQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    function automatic in_t mkIn(input logic r, input logic aV, input logic aT,
                                 input logic [XLEN-1:0] aTgt, input logic bV,
                                 input logic bT, input logic [XLEN-1:0] bTgt,
                                 input logic mV, input logic mR);
        in_t v;
        v.rst = r;  v.aV = aV; v.aT = aT; v.aTgt = aTgt;
        v.bV  = bV; v.bT = bT; v.bTgt = bTgt; v.mV = mV; v.mR = mR;
        return v;
    endfunction

    function automatic out_t mkOut(input logic rv, input logic lane,
                                   input logic [XLEN-1:0] tgt, input logic fA,
                                   input logic fB, input logic st,
                                   input logic md, input logic rdy);
        out_t o;
        o.rv = rv; o.lane = lane; o.tgt = tgt; o.fA = fA;
        o.fB = fB; o.st = st; o.md = md; o.rdy = rdy;
        return o;
    endfunction

    task automatic addVec(input in_t s, input out_t e);
        vec_t v;
        v.stim = s;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    task automatic checkOut();
        out_t act, exp;
        int   tag;
        if (expQ.size() == 0) return;
        exp = expQ.pop_front();
        tag = tagQ.pop_front();
        act.rv = pc_redirect_valid; act.lane = pc_redirect_lane;
        act.tgt = pc_redirect_target; act.fA = flushA; act.fB = flushB;
        act.st = issue_stall; act.md = mode; act.rdy = mode_req_ready;
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL step%0d: got rv=%0b lane=%0b tgt=%h fA=%0b fB=%0b stall=%0b mode=%0b rdy=%0b, expected rv=%0b lane=%0b tgt=%h fA=%0b fB=%0b stall=%0b mode=%0b rdy=%0b",
                     tag, act.rv, act.lane, act.tgt, act.fA, act.fB, act.st, act.md, act.rdy,
                     exp.rv, exp.lane, exp.tgt, exp.fA, exp.fB, exp.st, exp.md, exp.rdy);
        end else begin
            $display("[TB] step%0d ok: rv=%0b lane=%0b tgt=%h fA=%0b fB=%0b stall=%0b mode=%0b rdy=%0b",
                     tag, act.rv, act.lane, act.tgt, act.fA, act.fB, act.st, act.md, act.rdy);
        end
    endtask

    task automatic step(input in_t s, input out_t e, input int tag);
        @(negedge clk);
        checkOut();
        rst            = s.rst;
        brA_valid      = s.aV;
        brA_taken      = s.aT;
        brA_target     = s.aTgt;
        brB_valid      = s.bV;
        brB_taken      = s.bT;
        brB_target     = s.bTgt;
        mode_req_valid = s.mV;
        mode_req       = s.mR;
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, required completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_t idle;
        in_t rstIn;
        idle  = mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        rstIn = mkIn(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);

        rst = 1'b1;
        brA_valid = 1'b0; brA_taken = 1'b0; brA_target = '0;
        brB_valid = 1'b0; brB_taken = 1'b0; brB_target = '0;
        mode_req_valid = 1'b0; mode_req = 1'b0;

        // Outputs listed as: rv lane tgt fA fB stall mode rdy (after the edge)
        // Reset state, unified
        addVec(rstIn, mkOut(0, 0, 32'h0,   0, 0, 0, 1, 0));
        addVec(idle,  mkOut(0, 0, 32'h0,   0, 0, 0, 1, 0));
        // Unified lane A taken: both lanes flush for two cycles
        addVec(mkIn(0, 1, 1, 32'h100, 0, 0, 32'h0, 0, 0), mkOut(1, 0, 32'h100, 1, 1, 0, 1, 0));
        addVec(idle,  mkOut(0, 0, 32'h100, 1, 1, 0, 1, 0));
        addVec(idle,  mkOut(0, 0, 32'h100, 0, 0, 0, 1, 0));
        // Unified: lane B taken is ignored; lane A not-taken does nothing
        addVec(mkIn(0, 0, 0, 32'h0, 1, 1, 32'h555, 0, 0), mkOut(0, 0, 32'h100, 0, 0, 0, 1, 0));
        addVec(mkIn(0, 1, 0, 32'h999, 0, 0, 32'h0, 0, 0), mkOut(0, 0, 32'h100, 0, 0, 0, 1, 0));
        // Mode switch unified -> split
        addVec(mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0), mkOut(0, 0, 32'h100, 1, 1, 1, 1, 0));
        addVec(mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0), mkOut(0, 0, 32'h100, 1, 1, 1, 1, 0));
        addVec(mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0), mkOut(0, 0, 32'h100, 0, 0, 0, 0, 1));
        addVec(mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0), mkOut(0, 0, 32'h100, 0, 0, 0, 0, 0));
        addVec(idle,  mkOut(0, 0, 32'h100, 0, 0, 0, 0, 0));
        // Split: both lanes taken, A first, latched B one cycle later (new B ignored)
        addVec(mkIn(0, 1, 1, 32'h200, 1, 1, 32'h300, 0, 0), mkOut(1, 0, 32'h200, 1, 0, 1, 0, 0));
        addVec(mkIn(0, 0, 0, 32'h0, 1, 1, 32'hBBB, 0, 0),   mkOut(1, 1, 32'h300, 1, 1, 0, 0, 0));
        addVec(idle,  mkOut(0, 1, 32'h300, 0, 1, 0, 0, 0));
        // Lane A accepted while lane B still flushing
        addVec(mkIn(0, 1, 1, 32'h400, 0, 0, 32'h0, 0, 0), mkOut(1, 0, 32'h400, 1, 0, 0, 0, 0));
        addVec(idle,  mkOut(0, 0, 32'h400, 1, 0, 0, 0, 0));
        addVec(idle,  mkOut(0, 0, 32'h400, 0, 0, 0, 0, 0));
        // Split: lane B alone flushes only lane B
        addVec(mkIn(0, 0, 0, 32'h0, 1, 1, 32'h500, 0, 0), mkOut(1, 1, 32'h500, 0, 1, 0, 0, 0));
        addVec(idle,  mkOut(0, 1, 32'h500, 0, 1, 0, 0, 0));
        addVec(idle,  mkOut(0, 1, 32'h500, 0, 0, 0, 0, 0));
        // Mode request equal to current mode: immediate ack, no flush
        addVec(mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0), mkOut(0, 1, 32'h500, 0, 0, 0, 0, 1));
        addVec(idle,  mkOut(0, 1, 32'h500, 0, 0, 0, 0, 0));
        // Mode request coincident with a taken branch: redirect first
        addVec(mkIn(0, 1, 1, 32'h600, 0, 0, 32'h0, 1, 1), mkOut(1, 0, 32'h600, 1, 0, 0, 0, 0));
        addVec(mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1),   mkOut(0, 0, 32'h600, 1, 0, 0, 0, 0));
        addVec(mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1),   mkOut(0, 0, 32'h600, 0, 0, 0, 0, 0));
        addVec(mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1),   mkOut(0, 0, 32'h600, 1, 1, 1, 0, 0));
        addVec(mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1),   mkOut(0, 0, 32'h600, 1, 1, 1, 0, 0));
        addVec(mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1),   mkOut(0, 0, 32'h600, 0, 0, 0, 1, 1));
        addVec(idle,  mkOut(0, 0, 32'h600, 0, 0, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].stim, tbl[i].exp, i);
        end

        // Reset in the middle of a mode switch discards it
        step(mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0), mkOut(0, 0, 32'h600, 1, 1, 1, 1, 0), 100);
        step(mkIn(1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0), mkOut(0, 0, 32'h0,   0, 0, 0, 1, 0), 101);
        step(idle,                                     mkOut(0, 0, 32'h0,   0, 0, 0, 1, 0), 102);

        // Go split, then reset while the lane B redirect is pending
        step(mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0), mkOut(0, 0, 32'h0, 1, 1, 1, 1, 0), 200);
        step(mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0), mkOut(0, 0, 32'h0, 1, 1, 1, 1, 0), 201);
        step(mkIn(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0), mkOut(0, 0, 32'h0, 0, 0, 0, 0, 1), 202);
        step(idle,                                     mkOut(0, 0, 32'h0, 0, 0, 0, 0, 0), 203);
        step(mkIn(0, 1, 1, 32'h700, 1, 1, 32'h800, 0, 0), mkOut(1, 0, 32'h700, 1, 0, 1, 0, 0), 204);
        step(rstIn,                                    mkOut(0, 0, 32'h0, 0, 0, 0, 1, 0), 205);
        step(idle,                                     mkOut(0, 0, 32'h0, 0, 0, 0, 1, 0), 206);

        // Drain the last scoreboard entry
        @(negedge clk);
        checkOut();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
